// File: rtl/dsp_mux_reg_pkg.sv
// Shared DSP48A1 datapath constants and stage-mode encoding.
package dsp48a1_pkg;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int D_W = 18;
    localparam int C_W = 48;
    localparam int M_W = 36;
    localparam int P_W = 48;

    typedef enum logic {
        BYPASS = 1'b0,
        PIPE   = 1'b1
    } reg_mode_t;

endpackage

// File: rtl/dsp_mux_reg_if.sv
// Operand bundle for one DSP48A1 pipeline point.
// DSP_MUX_REG_PARITY_EN adds the PAR signal.
interface dsp_mux_reg_if #(
    parameter int WIDTH = 18
);
    logic             En;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] OUT;
`ifdef DSP_MUX_REG_PARITY_EN
    logic             PAR;

    modport master (output En, D, X, input OUT, PAR);
    modport slave  (input En, D, X, output OUT, PAR);
`else
    modport master (output En, D, X, input OUT);
    modport slave  (input En, D, X, output OUT);
`endif
endinterface

// File: rtl/dsp_en_ff.sv
// WIDTH-bit register with clock enable and async active-low clear.
module dsp_en_ff #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_mux_reg.sv
// Configurable DSP48A1 pipeline point: registered (REG=1) or bypass (REG=0).
// DSP_MUX_REG_PARITY_EN adds PAR = ^OUT.
module dsp_mux_reg
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int REG   = 1
) (
    input  logic         clk,
    input  logic         rst,
    dsp_mux_reg_if.slave bus
);

    generate
        if (REG == int'(PIPE)) begin : g_pipe
            logic [WIDTH-1:0] q;
            logic             unused_x;

            assign unused_x = ^bus.X;

            dsp_en_ff #(
                .WIDTH(WIDTH)
            ) u_ff (
                .clk  (clk),
                .rst_n(rst),
                .en   (bus.En),
                .d    (bus.D),
                .q    (q)
            );

            assign bus.OUT = q;
        end else if (REG == int'(BYPASS)) begin : g_bypass
            // Pure wire path: clock, reset and capture inputs are dead here.
            logic unused_in;

            assign unused_in = ^{clk, rst, bus.En, bus.D};
            assign bus.OUT   = bus.X;
        end else begin : g_bad
            $error("dsp_mux_reg: REG must be 0 or 1");
        end
    endgenerate

`ifdef DSP_MUX_REG_PARITY_EN
    assign bus.PAR = ^bus.OUT;
`endif

endmodule

// File: tb/tb_dsp_mux_reg.sv
// Randomized bench for dsp_mux_reg: one REG=1 and one REG=0 instance side by side.
`timescale 1ns/100ps
module tb_dsp_mux_reg;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] x;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Reference: value the pipe stage must be holding right now
    logic [W-1:0] m;

    dsp_mux_reg_if #(.WIDTH(W)) b1 ();
    dsp_mux_reg_if #(.WIDTH(W)) b0 ();

    assign b1.En = en;
    assign b1.D  = d;
    assign b1.X  = x;
    assign b0.En = en;
    assign b0.D  = d;
    assign b0.X  = x;

    dsp_mux_reg #(.WIDTH(W), .REG(1)) u_pipe (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    dsp_mux_reg #(.WIDTH(W), .REG(0)) u_byp (
        .clk(clk),
        .rst(rst),
        .bus(b0)
    );

    always #1 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) m = '0;
        else if (en) m = d;
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #0.5;
        if (chk_on) begin
            chk("pipe_out", b1.OUT, m);
            chk("byp_out", b0.OUT, x);
`ifdef DSP_MUX_REG_PARITY_EN
            chk("pipe_par", W'(b1.PAR), W'(^m));
            chk("byp_par", W'(b0.PAR), W'(^x));
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic at_post();
        @(posedge clk);
        #0.5;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        d   = '0;
        x   = '0;

        // reset hold with enable high
        cyc();
        d  = 18'h3FFFF;
        en = 1'b1;
        at_post();
        chk("rst_hold", b1.OUT, 18'h0);
        cyc();
        rst = 1'b1;
        d   = 18'h12345;
        at_post();
        chk("first_cap", b1.OUT, 18'h12345);
        chk_on = 1'b1;

        // back-to-back captures
        cyc(); d = 18'h00001;
        at_post(); chk("seq0", b1.OUT, 18'h00001);
        cyc(); d = 18'h2AAAA;
        at_post(); chk("seq1", b1.OUT, 18'h2AAAA);
        cyc(); d = 18'h15555;
        at_post(); chk("seq2", b1.OUT, 18'h15555);
        cyc(); d = 18'h2AAAA;
        at_post();

        // enable low: hold
        for (int i = 0; i < 10; i++) begin
            cyc();
            en = 1'b0;
            d  = W'($urandom);
            x  = W'($urandom);
            at_post();
        end
        chk("hold", b1.OUT, 18'h2AAAA);

        // async clear between edges
        cyc(); en = 1'b1; d = 18'h15555;
        at_post(); chk("pre_clr", b1.OUT, 18'h15555);
        cyc();
        #0.3 rst = 1'b0;
        #0.1 chk("async_clr", b1.OUT, 18'h0);
        cyc(); cyc();
        rst = 1'b1;

        // bypass follows X immediately, in and out of reset
        for (int i = 0; i < 10; i++) begin
            cyc();
            rst = (i >= 3);
            en  = i[0];
            d   = W'($urandom);
            x   = W'($urandom);
            #0.1 chk("byp_imm", b0.OUT, x);
        end
        cyc(); rst = 1'b1;

`ifdef DSP_MUX_REG_PARITY_EN
        cyc(); en = 1'b1; d = 18'h00007;
        at_post(); chk("par_odd", W'(b1.PAR), W'(1));
        cyc(); d = 18'h00003;
        at_post(); chk("par_even", W'(b1.PAR), W'(0));
`endif

        // random soak with occasional resets
        for (int i = 0; i < 300; i++) begin
            cyc();
            rst = ($urandom_range(0, 19) != 0);
            en  = $urandom_range(0, 1) != 0;
            d   = W'($urandom);
            x   = W'($urandom);
        end

        cyc();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
